// File: rtl/box_plotter.sv
// rtl/box_plotter.sv - box request FIFO expanded into row-major per-pixel VGA plot writes
// Optional clipping to the 160x120 visible area is enabled by defining BOX_PLOTTER_CLIP_EN.
module box_plotter #(
    parameter int BOX_W = 4,
    parameter int BOX_H = 3,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    input  logic [7:0] req_x,
    input  logic [6:0] req_y,
    input  logic [2:0] req_colour,
    output logic       req_ready,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       box_done,
    output logic       busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL    = PW'(DEPTH);
    localparam logic [2:0]    CX_LAST = 3'(BOX_W - 1);
    localparam logic [2:0]    CY_LAST = 3'(BOX_H - 1);

    typedef enum logic {S_IDLE, S_DRAW} state_t;

    logic [17:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, count_q;
    logic [PW-1:0] wr_ptr_d, rd_ptr_d, count_d;

    state_t     state_q, state_d;
    logic [2:0] cx_q, cx_d, cy_q, cy_d;
    logic [7:0] base_x_q, base_x_d;
    logic [6:0] base_y_q, base_y_d;
    logic [2:0] base_col_q, base_col_d;

    logic       push, pop, last_px;
    logic [17:0] head;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       clipped;

    assign req_ready = (count_q != FULL);
    assign push      = req_valid && req_ready;
    assign head      = mem_q[AW'(rd_ptr_q)];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[AW'(wr_ptr_q)] <= {req_x, req_y, req_colour};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // On the final pixel cx/cy are left in place so the coordinates hold through IDLE.
    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        base_x_d   = base_x_q;
        base_y_d   = base_y_q;
        base_col_d = base_col_q;
        pop        = 1'b0;
        last_px    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    {base_x_d, base_y_d, base_col_d} = head;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                last_px = (cx_q == CX_LAST) && (cy_q == CY_LAST);
                if (cx_q == CX_LAST) begin
                    if (cy_q == CY_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        cx_d = '0;
                        cy_d = cy_q + 3'd1;
                    end
                end else begin
                    cx_d = cx_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            cx_q       <= '0;
            cy_q       <= '0;
            base_x_q   <= '0;
            base_y_q   <= '0;
            base_col_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            base_x_q   <= base_x_d;
            base_y_q   <= base_y_d;
            base_col_q <= base_col_d;
        end
    end

    assign sum_x = {1'b0, base_x_q} + {6'd0, cx_q};
    assign sum_y = {1'b0, base_y_q} + {5'd0, cy_q};

`ifdef BOX_PLOTTER_CLIP_EN
    assign clipped = (sum_x >= 9'd160) || (sum_y >= 8'd120);
`else
    assign clipped = 1'b0;
`endif

    assign vga_x      = sum_x[7:0];
    assign vga_y      = sum_y[6:0];
    assign vga_colour = base_col_q;
    assign plot       = (state_q == S_DRAW) && !clipped;
    assign box_done   = last_px;
    assign busy       = (count_q != '0) || (state_q != S_IDLE);
endmodule
